// File: rtl/my_accum_ch.sv
// my_accum_ch: per-channel windowed accumulator fed by a time-multiplexed sample stream.
// Each channel emits its window total and an overflow flag once every WINDOW accepted samples.
module my_accum_ch #(
  parameter int IN_WIDTH   = 5,
  parameter int SUM_LENGTH = 10,
  parameter int CHANNELS   = 4,
  parameter int WINDOW     = 16,
  parameter int SAT        = 0,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [CH_W-1:0]       in_ch,
  input  logic [IN_WIDTH-1:0]   in,
  output logic                  out_valid,
  output logic [CH_W-1:0]       out_ch,
  output logic [SUM_LENGTH-1:0] out_sum,
  output logic                  out_ovf
);

  localparam int               CNT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(CHANNELS);

  logic [SUM_LENGTH-1:0] r_acc [CHANNELS];
  logic [CNT_W-1:0]      r_cnt [CHANNELS];
  logic [CHANNELS-1:0]   r_ovf;

  logic                  w_accept;
  logic                  w_last;
  logic [SUM_LENGTH:0]   w_sum_ext;
  logic                  w_carry;
  logic [SUM_LENGTH-1:0] w_sum;

  // Out-of-range channel indices are dropped here, so the array reads below are only used when legal.
  assign w_accept  = in_valid && !clr && ({1'b0, in_ch} < CH_LIMIT);
  assign w_last    = (r_cnt[in_ch] == CNT_LAST);
  assign w_sum_ext = {1'b0, r_acc[in_ch]} + (SUM_LENGTH + 1)'(in);
  assign w_carry   = w_sum_ext[SUM_LENGTH];
  assign w_sum     = ((SAT != 0) && w_carry) ? '1 : w_sum_ext[SUM_LENGTH-1:0];

  // NOTE: all state uses non-blocking assignments so every read in this block sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the per-channel arrays are small flop banks, not RAM, so resetting them is legal and required.
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c] <= '0;
        r_cnt[c] <= '0;
      end
      r_ovf     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (clr) begin
        for (int c = 0; c < CHANNELS; c++) begin
          r_acc[c] <= '0;
          r_cnt[c] <= '0;
        end
        r_ovf <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          out_valid     <= 1'b1;
          out_ch        <= in_ch;
          out_sum       <= w_sum;
          out_ovf       <= r_ovf[in_ch] | w_carry;
          r_acc[in_ch]  <= '0;
          r_cnt[in_ch]  <= '0;
          r_ovf[in_ch]  <= 1'b0;
        end else begin
          r_acc[in_ch]  <= w_sum;
          r_cnt[in_ch]  <= r_cnt[in_ch] + CNT_W'(1);
          r_ovf[in_ch]  <= r_ovf[in_ch] | w_carry;
        end
      end
    end
  end

endmodule

// File: doc/my_accum_ch.md
# my_accum_ch

Multi-channel windowed accumulator: the parametrised successor of the single-channel free-running adder. It sums unsigned samples per channel over a fixed window of WINDOW valid samples. At the end of each window it emits the channel's total with an overflow flag, then restarts that channel from zero. It sits between the sample front-end (time-multiplexed channel stream) and the statistics/readout logic.

## Interface

- IN_WIDTH, 5: sample width, unsigned.
- SUM_LENGTH, 10 (`SUM_LENGTH` from params.v): accumulator and output width.
- CHANNELS, 4: number of independent accumulators, ≥1.
- WINDOW, 16: valid samples per channel per window, ≥1.
- SAT, 0: overflow mode. 0 = wrap modulo 2^SUM_LENGTH; 1 = clamp at 2^SUM_LENGTH−1.
- CH_W (derived) = max(1, clog2(CHANNELS)).

Ports:

- clk  input  1  single clock; all logic on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear of all channels.
- in_valid  input  1  sample qualifier.
- in_ch  input  CH_W  channel index of sample.
- in  input  IN_WIDTH  sample value, unsigned.
- out_valid  output  1  one-cycle pulse: window complete.
- out_ch  output  CH_W  channel of completed window.
- out_sum  output  SUM_LENGTH  window total.
- out_ovf  output  1  overflow occurred inside this window.

## Operation

- Per channel c: acc[c] (SUM_LENGTH), cnt[c] (counts 0..WINDOW−1), ovf[c] (sticky within window).
- Accepted sample: in_valid=1, in_ch<CHANNELS, clr=0. Samples with in_ch≥CHANNELS are ignored and change no state.
- Accepted sample, cnt[c]<WINDOW−1: acc[c] ← f(acc[c]+in), cnt[c] ← cnt[c]+1, ovf[c] ← ovf[c] | carry.
- Accepted sample, cnt[c]=WINDOW−1 (window end):
  - out_sum ← f(acc[c]+in); the closing sample is included.
  - out_ovf ← ovf[c] | carry; out_ch ← c; out_valid ← 1.
  - acc[c], cnt[c] and ovf[c] return to 0.
- f(): the addition is computed at SUM_LENGTH+1 bits; carry = bit SUM_LENGTH. With SAT=0, result = low SUM_LENGTH bits. With SAT=1, result = all-ones when carry=1.
- Once saturated, the accumulator stays at all-ones for the rest of the window (SAT=1).
- in is zero-extended to SUM_LENGTH before the add.
- WINDOW=1: every accepted sample produces an output immediately.
- clr=1: all acc, cnt and ovf are cleared. clr has priority over a simultaneous sample, which is dropped. out_valid=0 in that cycle.
- Channels are fully independent; interleaving order on in_ch is arbitrary.
- There is no backpressure; the consumer must take out_* whenever out_valid=1.

## Timing

- Reset (resetn=0, asynchronous) sets out_valid=0, out_ch=0, out_sum=0, out_ovf=0, and clears all acc, cnt and ovf. The first accepted sample is on the first rising edge with resetn=1.
- Latency: a window-closing sample on edge N produces out_valid=1 with data valid after edge N+1, i.e. registered outputs with one cycle of latency.
- out_valid is high for exactly one cycle per completed window.
  - out_ch, out_sum and out_ovf hold their last value while out_valid=0.
- Throughput: one sample per cycle, including back-to-back samples on the same channel and consecutive window closes on different channels.
- Reset asserted mid-window discards partial sums; no output is produced for the aborted window.

## Test plan

- Reset/defaults: release resetn, keep in_valid=0 for 5 cycles → all outputs 0, out_valid never high.
- Single channel, defaults: 16 samples in=3 on ch0 → one out_valid pulse one cycle after the 16th, out_ch=0, out_sum=48, out_ovf=0. The next 16 samples in=1 → out_sum=16, confirming the restart.
- Interleave: alternate ch1 in=31 and ch2 in=2, 16 each → ch1 out_sum=496, ch2 out_sum=32, each a separate one-cycle pulse in completion order. Add a sample with in_ch≥CHANNELS when CHANNELS=3 → ignored.
- Overflow: SUM_LENGTH=8, 16×in=31 on ch0.
  - SAT=0 → out_sum=496 mod 256=240, out_ovf=1.
  - SAT=1 → out_sum=255, out_ovf=1.
  - Next window 16×in=1 → out_ovf=0.
- clr priority: 10 samples in=5 on ch3, then clr with in_valid=1 in the same cycle, then 16 samples in=2 → out_sum=32, with no output for the aborted window.
- Async reset mid-window: assert resetn=0 off-edge after 8 samples → outputs go to 0 immediately. After release, 16 samples in=4 → out_sum=64.
